sysid_check_sequencer: RTL and testbench
========================================

// Module: sysid_check_sequencer
// PURPOSE
// Boot-time sequencer and bus owner for the 32-bit, 1-bit-address system-ID slave.
// After reset it reads the ID word (addr 0) and the timestamp word (addr 1).
// It compares both against expected values, retries on failure and reports the verdict.
// Outside a check it passes host (CPU-side) reads through to the slave; the checker has priority.
// PARAMETERS
// EXPECTED_ID     32'h43520D20  value required at sysid address 0
// EXPECTED_TS     32'h4C3424BF  value required at sysid address 1
// TIMEOUT_CYCLES  255           max consecutive waitrequest cycles per read before abort (1..65535)
// MAX_RETRIES     3             extra full check passes after a failed pass (0..15)
// AUTO_START      1             1: start a check on the first cycle after reset deasserts
// PORTS
// clock              in   1   single clock; all state rises on posedge
// reset              in   1   asynchronous, active-high reset
// start              in   1   1-cycle pulse: run a check (ignored while busy)
// host_read          in   1   host read request; hold until accepted
// host_address       in   1   host word select
// host_waitrequest   out  1   1 = host request not accepted this cycle
// host_readdata      out  32  valid in the cycle host_read=1 and host_waitrequest=0
// sid_read           out  1   read strobe to the sysid slave
// sid_address        out  1   word select to the sysid slave
// sid_waitrequest    in   1   slave/fabric stall; tie 0 for a direct connection
// sid_readdata       in   32  captured in the cycle sid_read=1 and sid_waitrequest=0
// busy               out  1   check in progress
// done               out  1   sticky: a check has completed (cleared when a new check starts)
// id_ok / ts_ok      out  1   comparison results of the last completed pass
// timeout_err        out  1   last pass aborted on timeout
// id_value/ts_value  out  32  last words captured from addr 0 / addr 1
// BEHAVIOUR
// - Reset: all outputs 0, except host_waitrequest=1 while reset is high. FSM=IDLE, retry count=0, timeout count=0.
// - FSM states: IDLE, RD_ID, RD_TS, EVAL, HOST.
//   - IDLE->RD_ID on start, or on the first post-reset cycle if AUTO_START. On entry: busy=1, done=0, flags cleared.
//   - RD_ID: sid_read=1, sid_address=0. On accept, latch id_value and go to RD_TS.
//   - RD_TS: sid_read=1, sid_address=1. On accept, latch ts_value and go to EVAL.
//   - EVAL (1 cycle): id_ok=(id_value==EXPECTED_ID), ts_ok=(ts_value==EXPECTED_TS).
//     - Both ok, or retries==MAX_RETRIES: done=1, busy=0, go to IDLE.
//     - Otherwise: retries+1, go to RD_ID.
//   - Timeout counter: cleared on every accept or state change; increments each cycle sid_read=1 and sid_waitrequest=1.
//     When it reaches TIMEOUT_CYCLES, drop sid_read and set timeout_err=1, id_ok=ts_ok=0. Then retry or finish as in EVAL.
// - Latency: with sid_waitrequest=0, a pass is 3 cycles: RD_ID, RD_TS, EVAL. done rises 3 cycles after start is sampled.
// - Arbitration:
//   - A host read is considered only in IDLE; start or auto-start has priority in the same cycle.
//   - Grant: IDLE->HOST. In HOST, sid_read=host_read, sid_address=host_address, host_waitrequest=sid_waitrequest,
//     host_readdata=sid_readdata (combinational pass-through).
//   - HOST->IDLE in the cycle the host read is accepted. The host owns the bus until accept; a start pulse seen in HOST is lost.
//   - In all non-HOST states host_waitrequest=1 and host_readdata=0.
//   - Host reads carry no timeout.
// - start while busy or in HOST: ignored. Results registers hold until the next check begins.
// - Retry count is 4 bits and never wraps: retries stop at MAX_RETRIES.
// - Reset mid-read: immediate return to reset values; sid_read drops asynchronously.
// TESTING
// - Slave returns the expected words, waitrequest=0, AUTO_START=1: done=1 on the 4th cycle after reset release; id_ok=ts_ok=1, busy=0.
// - Addr 0 returns 32'h0: 4 passes of 3 cycles each; final done=1, id_ok=0, ts_ok=1, id_value=0.
// - sid_waitrequest held 1 in RD_ID, TIMEOUT_CYCLES=8, MAX_RETRIES=0: sid_read low after 8 stall cycles; done=1, timeout_err=1, id_ok=ts_ok=0.
// - start and host_read(addr 1) in the same IDLE cycle: checker runs first with host_waitrequest=1; the host is then granted and reads EXPECTED_TS.
// - Host read stalled 5 cycles by waitrequest, start pulsed mid-stall: host gets data in cycle 6; start is lost; busy stays 0.
// - Reset asserted while in RD_TS with waitrequest=1: sid_read=0, busy=0 and done=0 immediately; a fresh auto-check runs after release.

Source files
------------

// File: rtl/sysid_check_sequencer_if.sv
// Word-read bus with waitrequest stall, used both for the host port and the
// system-ID slave port of the check sequencer.
interface sysid_check_sequencer_if;
    logic        read;
    logic        address;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output read,
        output address,
        input  waitrequest,
        input  readdata
    );

    modport slave (
        input  read,
        input  address,
        output waitrequest,
        output readdata
    );
endinterface

// File: rtl/sysid_check_sequencer.sv
// Boot-time checker for the system-ID slave: reads ID and timestamp words, compares
// them with expected values with bounded retries, and otherwise lends the bus to the host.
module sysid_check_sequencer #(
    parameter logic [31:0] EXPECTED_ID    = 32'h43520D20,
    parameter logic [31:0] EXPECTED_TS    = 32'h4C3424BF,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic                           i_start,
    sysid_check_sequencer_if.slave         i_host,
    sysid_check_sequencer_if.master        o_sid,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_id_ok,
    output logic                           o_ts_ok,
    output logic                           o_timeout_err,
    output logic [31:0]                    o_id_value,
    output logic [31:0]                    o_ts_value
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ID,
        S_RD_TS,
        S_EVAL,
        S_HOST
    } state_t;

    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic        r_auto;
    logic [3:0]  r_retries;
    logic [15:0] r_tmo_cnt;

    logic w_rd_state;
    logic w_host;
    logic w_accept;
    logic w_timeout;
    logic w_pass_ok;

    assign w_rd_state = (r_state == S_RD_ID) || (r_state == S_RD_TS);
    assign w_host     = (r_state == S_HOST);
    assign w_accept   = w_rd_state && !o_sid.waitrequest;
    assign w_timeout  = w_rd_state && o_sid.waitrequest && (r_tmo_cnt == TMO_LAST);
    assign w_pass_ok  = !o_timeout_err && (o_id_value == EXPECTED_ID) && (o_ts_value == EXPECTED_TS);

    // The host path is purely combinational so a granted host sees the slave directly.
    always_comb begin
        o_sid.read         = w_rd_state || (w_host && i_host.read);
        o_sid.address      = w_host ? i_host.address : (r_state == S_RD_TS);
        i_host.waitrequest = w_host ? o_sid.waitrequest : 1'b1;
        i_host.readdata    = w_host ? o_sid.readdata : 32'h0;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_auto        <= AUTO_START;
            r_retries     <= 4'h0;
            r_tmo_cnt     <= 16'h0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_id_ok       <= 1'b0;
            o_ts_ok       <= 1'b0;
            o_timeout_err <= 1'b0;
            o_id_value    <= 32'h0;
            o_ts_value    <= 32'h0;
        end else begin
            r_auto <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start || r_auto) begin
                        r_state       <= S_RD_ID;
                        r_retries     <= 4'h0;
                        r_tmo_cnt     <= 16'h0;
                        o_busy        <= 1'b1;
                        o_done        <= 1'b0;
                        o_id_ok       <= 1'b0;
                        o_ts_ok       <= 1'b0;
                        o_timeout_err <= 1'b0;
                    end else if (i_host.read) begin
                        r_state <= S_HOST;
                    end
                end
                S_RD_ID, S_RD_TS: begin
                    if (w_accept) begin
                        r_tmo_cnt <= 16'h0;
                        if (r_state == S_RD_ID) begin
                            o_id_value <= o_sid.readdata;
                            r_state    <= S_RD_TS;
                        end else begin
                            o_ts_value <= o_sid.readdata;
                            r_state    <= S_EVAL;
                        end
                    end else if (w_timeout) begin
                        // Abort lands in EVAL, which forces both verdicts low for this pass.
                        r_tmo_cnt     <= 16'h0;
                        o_timeout_err <= 1'b1;
                        r_state       <= S_EVAL;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    end
                end
                S_EVAL: begin
                    r_tmo_cnt <= 16'h0;
                    o_id_ok   <= !o_timeout_err && (o_id_value == EXPECTED_ID);
                    o_ts_ok   <= !o_timeout_err && (o_ts_value == EXPECTED_TS);
                    if (w_pass_ok || (r_retries == RETRY_MAX) || (r_retries == 4'hF)) begin
                        o_done  <= 1'b1;
                        o_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_retries     <= r_retries + 4'd1;
                        o_timeout_err <= 1'b0;
                        r_state       <= S_RD_ID;
                    end
                end
                S_HOST: begin
                    if (i_host.read && !o_sid.waitrequest) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sysid_check_sequencer.sv
// Randomised bench for sysid_check_sequencer: a planned-response slave plus a
// pass-level model predicting check duration and verdict.
module tb_sysid_check_sequencer;
    localparam logic [31:0] EXP_ID = 32'h43520D20;
    localparam logic [31:0] EXP_TS = 32'h4C3424BF;
    localparam int          T      = 8;
    localparam int          MAXR   = 3;

    typedef struct {
        int          stall;
        logic        addr;
        logic [31:0] data;
    } resp_t;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, id_ok, ts_ok, tmo;
    logic [31:0] idv, tsv;
    int          errors = 0;
    int          checks = 0;

    sysid_check_sequencer_if host_if();
    sysid_check_sequencer_if sid_if();

    sysid_check_sequencer #(
        .EXPECTED_ID   (EXP_ID),
        .EXPECTED_TS   (EXP_TS),
        .TIMEOUT_CYCLES(T),
        .MAX_RETRIES   (MAXR),
        .AUTO_START    (1'b1)
    ) u_dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_start      (start),
        .i_host       (host_if),
        .o_sid        (sid_if),
        .o_busy       (busy),
        .o_done       (done),
        .o_id_ok      (id_ok),
        .o_ts_ok      (ts_ok),
        .o_timeout_err(tmo),
        .o_id_value   (idv),
        .o_ts_value   (tsv)
    );

    always #5 clk = ~clk;

    // Slave: each new read transaction takes the next planned response.
    resp_t       plan[$];
    int          s_stall = 0;
    bit          s_active = 1'b0;
    bit          s_prev_read = 1'b0;
    bit          s_prev_wait = 1'b0;
    logic [31:0] s_data = '0;

    always @(posedge clk) begin
        resp_t e;
        if (rst) s_active = 1'b0;
        else if (s_active && s_prev_read) begin
            if (!s_prev_wait) s_active = 1'b0;
            else s_stall--;
        end
        #2;
        if (sid_if.read !== 1'b1) begin
            s_active = 1'b0;
            sid_if.waitrequest = 1'b0;
            sid_if.readdata = '0;
        end else begin
            if (!s_active) begin
                s_active = 1'b1;
                checks++;
                if (plan.size() == 0) begin
                    errors++;
                    $display("FAIL slave_plan: unplanned read at addr %0d", sid_if.address);
                    s_stall = 0;
                    s_data = '0;
                end else begin
                    e = plan.pop_front();
                    if (sid_if.address !== e.addr) begin
                        errors++;
                        $display("FAIL slave_addr: got %0d expected %0d", sid_if.address, e.addr);
                    end
                    s_stall = e.stall;
                    s_data = e.data;
                end
            end
            sid_if.waitrequest = (s_stall > 0);
            sid_if.readdata = s_data;
        end
        s_prev_read = (sid_if.read === 1'b1);
        s_prev_wait = sid_if.waitrequest;
    end

    // Reference model: up to 1+MAXR passes; a read stalled T or more cycles aborts the pass.
    int          m_cycles;
    logic        m_idok, m_tsok, m_tmo;
    logic [31:0] m_id = '0;
    logic [31:0] m_ts = '0;

    task automatic model_check(input resp_t src[$]);
        int idx = 0;
        bit t;
        m_cycles = 1;
        for (int pass = 0; pass <= MAXR; pass++) begin
            t = 1'b0;
            if (src[idx].stall >= T) begin
                m_cycles += T;
                t = 1'b1;
            end else begin
                m_cycles += src[idx].stall + 1;
                m_id = src[idx].data;
            end
            plan.push_back(resp_t'{src[idx].stall, 1'b0, src[idx].data});
            idx++;
            if (!t) begin
                if (src[idx].stall >= T) begin
                    m_cycles += T;
                    t = 1'b1;
                end else begin
                    m_cycles += src[idx].stall + 1;
                    m_ts = src[idx].data;
                end
                plan.push_back(resp_t'{src[idx].stall, 1'b1, src[idx].data});
                idx++;
            end
            m_cycles += 1;
            m_tmo  = t;
            m_idok = !t && (m_id == EXP_ID);
            m_tsok = !t && (m_ts == EXP_TS);
            if (m_idok && m_tsok) break;
        end
    endtask

    task automatic good_src(output resp_t src[$]);
        src.delete();
        for (int i = 0; i < 4; i++) begin
            src.push_back(resp_t'{0, 1'b0, EXP_ID});
            src.push_back(resp_t'{0, 1'b1, EXP_TS});
        end
    endtask

    task automatic launch(input bit via_reset, output int cyc);
        @(posedge clk);
        #1;
        if (via_reset) rst = 1'b0;
        else start = 1'b1;
        cyc = -1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            if (done === 1'b1) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resp_t src[$];
        int cyc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, id_ok, ts_ok, tmo, idv, tsv, sid_if.read, sid_if.address, host_if.waitrequest, host_if.readdata}
            !== {5'b0, 64'h0, 2'b00, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b ok=%b%b tmo=%b id=%h ts=%h rd=%b hw=%b hd=%h, expected zeros with hw=1",
                     busy, done, id_ok, ts_ok, tmo, idv, tsv, sid_if.read, host_if.waitrequest, host_if.readdata);
        end
        m_id = '0;
        m_ts = '0;
        good_src(src);
        model_check(src);
        launch(1'b1, cyc);
        checks++;
        if (cyc !== m_cycles) begin
            errors++;
            $display("FAIL auto_start_latency: got %0d expected %0d", cyc, m_cycles);
        end
        checks++;
        if ({busy, done, id_ok, ts_ok, tmo, idv, tsv} !== {1'b0, 1'b1, m_idok, m_tsok, m_tmo, m_id, m_ts}) begin
            errors++;
            $display("FAIL auto_start_status: got %b%b%b%b%b %h %h expected 01%b%b%b %h %h",
                     busy, done, id_ok, ts_ok, tmo, idv, tsv, m_idok, m_tsok, m_tmo, m_id, m_ts);
        end
    endtask

    task automatic test_bad_id();
        resp_t src[$];
        int cyc;
        for (int i = 0; i < 4; i++) begin
            src.push_back(resp_t'{0, 1'b0, 32'h0});
            src.push_back(resp_t'{0, 1'b1, EXP_TS});
        end
        model_check(src);
        launch(1'b0, cyc);
        checks++;
        if (cyc !== m_cycles) begin
            errors++;
            $display("FAIL bad_id_cycles: got %0d expected %0d", cyc, m_cycles);
        end
        checks++;
        if ({busy, done, id_ok, ts_ok, tmo, idv, tsv} !== {1'b0, 1'b1, m_idok, m_tsok, m_tmo, m_id, m_ts}) begin
            errors++;
            $display("FAIL bad_id_status: got %b%b%b%b%b %h %h expected 01%b%b%b %h %h",
                     busy, done, id_ok, ts_ok, tmo, idv, tsv, m_idok, m_tsok, m_tmo, m_id, m_ts);
        end
    endtask

    task automatic test_timeout();
        resp_t src[$];
        int cyc = -1;
        for (int i = 0; i < 8; i++) src.push_back(resp_t'{20, 1'b0, $urandom});
        model_check(src);
        @(posedge clk);
        #1 start = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            if (k == T) begin
                checks++;
                if (sid_if.read !== 1'b1) begin
                    errors++;
                    $display("FAIL timeout_last_stall: sid_read=%b expected 1", sid_if.read);
                end
            end
            if (k == T + 1) begin
                checks++;
                if (sid_if.read !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_abort: sid_read=%b expected 0", sid_if.read);
                end
            end
            if (done === 1'b1) begin
                cyc = k;
                break;
            end
        end
        checks++;
        if (cyc !== m_cycles) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d expected %0d", cyc, m_cycles);
        end
        checks++;
        if ({busy, done, id_ok, ts_ok, tmo, idv, tsv} !== {1'b0, 1'b1, m_idok, m_tsok, m_tmo, m_id, m_ts}) begin
            errors++;
            $display("FAIL timeout_status: got %b%b%b%b%b %h %h expected 01%b%b%b %h %h",
                     busy, done, id_ok, ts_ok, tmo, idv, tsv, m_idok, m_tsok, m_tmo, m_id, m_ts);
        end
    endtask

    task automatic test_random();
        resp_t src[$];
        int cyc, st;
        logic [31:0] d;
        for (int it = 0; it < 25; it++) begin
            src.delete();
            for (int i = 0; i < 8; i++) begin
                case ($urandom_range(0, 7))
                    5:       st = T - 1;
                    6:       st = T;
                    7:       st = $urandom_range(0, T + 3);
                    4:       st = 1;
                    default: st = 0;
                endcase
                if ($urandom_range(0, 9) < 8) d = (i % 2 == 0) ? EXP_ID : EXP_TS;
                else d = $urandom;
                src.push_back(resp_t'{st, 1'b0, d});
            end
            model_check(src);
            launch(1'b0, cyc);
            checks++;
            if (cyc !== m_cycles) begin
                errors++;
                $display("FAIL random_cycles[%0d]: got %0d expected %0d", it, cyc, m_cycles);
            end
            checks++;
            if ({busy, done, id_ok, ts_ok, tmo, idv, tsv} !== {1'b0, 1'b1, m_idok, m_tsok, m_tmo, m_id, m_ts}) begin
                errors++;
                $display("FAIL random_status[%0d]: got %b%b%b%b%b %h %h expected 01%b%b%b %h %h", it,
                         busy, done, id_ok, ts_ok, tmo, idv, tsv, m_idok, m_tsok, m_tmo, m_id, m_ts);
            end
        end
    endtask

    task automatic test_start_and_host();
        resp_t src[$];
        int cyc = -1;
        int acc = -1;
        int hw_viol = 0;
        logic [31:0] got = '0;
        good_src(src);
        model_check(src);
        plan.push_back(resp_t'{0, 1'b1, EXP_TS});
        @(posedge clk);
        #1;
        start = 1'b1;
        host_if.read = 1'b1;
        host_if.address = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            if (host_if.waitrequest !== 1'b1) hw_viol++;
            if (done === 1'b1) begin
                cyc = k;
                break;
            end
        end
        checks++;
        if (cyc !== m_cycles || hw_viol != 0) begin
            errors++;
            $display("FAIL checker_priority: cycles=%0d host_grants=%0d expected cycles=%0d grants=0", cyc, hw_viol, m_cycles);
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (host_if.waitrequest === 1'b0) begin
                acc = k;
                got = host_if.readdata;
                break;
            end
        end
        @(posedge clk);
        #1 host_if.read = 1'b0;
        checks++;
        if (acc !== 1 || got !== EXP_TS) begin
            errors++;
            $display("FAIL host_after_check: accepted at %0d data %h expected 1 and %h", acc, got, EXP_TS);
        end
        @(negedge clk);
        checks++;
        if (host_if.waitrequest !== 1'b1 || host_if.readdata !== 32'h0) begin
            errors++;
            $display("FAIL host_release: hw=%b hd=%h expected 1 and 0", host_if.waitrequest, host_if.readdata);
        end
    endtask

    task automatic test_host_stall();
        int acc = -1;
        bit busy_seen = 1'b0;
        logic [31:0] word = $urandom;
        logic [31:0] got = '0;
        plan.push_back(resp_t'{5, 1'b0, word});
        @(posedge clk);
        #1;
        host_if.read = 1'b1;
        host_if.address = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1 start = (k == 3);
            @(negedge clk);
            if (busy !== 1'b0) busy_seen = 1'b1;
            if (host_if.waitrequest === 1'b0) begin
                acc = k;
                got = host_if.readdata;
                break;
            end
        end
        @(posedge clk);
        #1;
        host_if.read = 1'b0;
        start = 1'b0;
        checks++;
        if (acc !== 6 || got !== word) begin
            errors++;
            $display("FAIL host_stall_data: accepted at %0d data %h expected 6 and %h", acc, got, word);
        end
        repeat (4) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_seen = 1'b1;
        end
        checks++;
        if (busy_seen || done !== 1'b1 || sid_if.read !== 1'b0) begin
            errors++;
            $display("FAIL host_start_lost: busy_seen=%b done=%b sid_read=%b expected 0 1 0", busy_seen, done, sid_if.read);
        end
    endtask

    task automatic test_reset_mid_read();
        resp_t src[$];
        int cyc;
        plan.push_back(resp_t'{0, 1'b0, EXP_ID});
        plan.push_back(resp_t'{20, 1'b1, EXP_TS});
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (sid_if.read !== 1'b1 || sid_if.address !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rd_ts_reached: rd=%b addr=%b busy=%b expected 1 1 1", sid_if.read, sid_if.address, busy);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({sid_if.read, busy, done, host_if.waitrequest} !== 4'b0001) begin
            errors++;
            $display("FAIL async_reset: rd=%b busy=%b done=%b hw=%b expected 0 0 0 1",
                     sid_if.read, busy, done, host_if.waitrequest);
        end
        plan.delete();
        m_id = '0;
        m_ts = '0;
        good_src(src);
        model_check(src);
        launch(1'b1, cyc);
        checks++;
        if (cyc !== m_cycles) begin
            errors++;
            $display("FAIL reset_recheck_cycles: got %0d expected %0d", cyc, m_cycles);
        end
        checks++;
        if ({busy, done, id_ok, ts_ok, tmo, idv, tsv} !== {1'b0, 1'b1, m_idok, m_tsok, m_tmo, m_id, m_ts}) begin
            errors++;
            $display("FAIL reset_recheck_status: got %b%b%b%b%b %h %h expected 01%b%b%b %h %h",
                     busy, done, id_ok, ts_ok, tmo, idv, tsv, m_idok, m_tsok, m_tmo, m_id, m_ts);
        end
    endtask

    initial begin
        host_if.read = 1'b0;
        host_if.address = 1'b0;
        test_reset();
        test_bad_id();
        test_timeout();
        test_random();
        test_start_and_host();
        test_host_stall();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
